// File: rtl/npu_pkg.sv
// Shared NPU definitions: local-buffer source selects, controller modes and
// the result-buffer state encoding that the controller decodes.
package npu_pkg;

   localparam logic [1:0] BUF_SEL_NONE = 2'b00;
   localparam logic [1:0] BUF_SEL_PU   = 2'b01;
   localparam logic [1:0] BUF_SEL_POOL = 2'b10;
   localparam logic [1:0] BUF_SEL_CTRL = 2'b11;

   localparam logic [2:0] MODE_IDLE = 3'd0;
   localparam logic [2:0] MODE_CONV = 3'd1;
   localparam logic [2:0] MODE_POOL = 3'd2;
   localparam logic [2:0] MODE_FC   = 3'd3;

   typedef enum logic [1:0] {
      BUF_IDLE  = 2'd0,
      BUF_DRAIN = 2'd1,
      BUF_DONE  = 2'd2
   } buf_state_e;

   function automatic logic is_write_sel(input logic [1:0] sel);
      return (sel == BUF_SEL_PU) || (sel == BUF_SEL_POOL);
   endfunction

endpackage

// File: rtl/npu_buf_mem.sv
// Result word storage: DEPTH x DATA_W register array with one synchronous
// write port and one combinational read port.
module npu_buf_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // No reset on the array: readers only look at entries below the count.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/npu_local_buffer.sv
// Local result buffer: captures PU/pool words while idle, then drains them as
// a valid/ready stream under controller command and reports read_done.
module npu_local_buffer
   import npu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [1:0]        i_sel_local_buffer,
   input  logic              i_en_local_buffer,
   input  logic              i_term,
   input  logic              i_pu_valid,
   input  logic [DATA_W-1:0] i_pu_data,
   input  logic              i_pool_valid,
   input  logic [DATA_W-1:0] i_pool_data,
   output logic              o_m_valid,
   output logic [DATA_W-1:0] o_m_data,
   output logic              o_m_last,
   input  logic              i_m_ready,
   output logic              o_read_done,
   output logic [ADDR_W:0]   o_count,
   output logic              o_overflow,
   output logic [1:0]        o_state
);

   // Stream handshake: a beat transfers on a rising edge where o_m_valid and
   // i_m_ready are both high; o_m_data/o_m_last hold steady while ready is low.

   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   buf_state_e        state, state_nxt;
   logic [ADDR_W:0]   count, count_nxt;
   logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
   logic              overflow, overflow_nxt;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;
   logic              drain_req;
   logic              src_valid;
   logic              at_last;

   assign drain_req = (i_sel_local_buffer == BUF_SEL_CTRL) && i_en_local_buffer;
   assign src_valid = ((i_sel_local_buffer == BUF_SEL_PU)   && i_pu_valid) ||
                      ((i_sel_local_buffer == BUF_SEL_POOL) && i_pool_valid);
   assign wr_data   = (i_sel_local_buffer == BUF_SEL_POOL) ? i_pool_data : i_pu_data;
   assign at_last   = ({1'b0, rd_ptr} == (count - CNT_ONE));

   npu_buf_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .i_clk   (i_clk),
      .wr_en   (wr_en),
      .wr_addr (count[ADDR_W-1:0]),
      .wr_data (wr_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= BUF_IDLE;
         count    <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         count    <= count_nxt;
         rd_ptr   <= rd_ptr_nxt;
         overflow <= overflow_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      count_nxt    = count;
      rd_ptr_nxt   = rd_ptr;
      overflow_nxt = overflow;
      wr_en        = 1'b0;
      case (state)
         BUF_IDLE: begin
            if (src_valid) begin
               if (count == CNT_FULL) begin
                  overflow_nxt = 1'b1;
               end else begin
                  wr_en     = 1'b1;
                  count_nxt = count + CNT_ONE;
               end
            end else if (drain_req) begin
               rd_ptr_nxt = '0;
               state_nxt  = (count != '0) ? BUF_DRAIN : BUF_DONE;
            end
         end
         BUF_DRAIN: begin
            // Losing the CTRL grant aborts the drain but keeps the contents.
            if (!drain_req) begin
               state_nxt  = BUF_IDLE;
               rd_ptr_nxt = '0;
            end else if (i_m_ready) begin
               if (at_last) state_nxt  = BUF_DONE;
               else         rd_ptr_nxt = rd_ptr + PTR_ONE;
            end
         end
         BUF_DONE: begin
            if (!i_en_local_buffer) begin
               state_nxt  = BUF_IDLE;
               count_nxt  = '0;
               rd_ptr_nxt = '0;
            end
         end
         default: begin
            state_nxt  = BUF_IDLE;
            rd_ptr_nxt = '0;
         end
      endcase
      if (i_term) begin
         state_nxt    = BUF_IDLE;
         count_nxt    = '0;
         rd_ptr_nxt   = '0;
         overflow_nxt = 1'b0;
         wr_en        = 1'b0;
      end
   end

   assign o_m_valid   = (state == BUF_DRAIN);
   assign o_m_data    = o_m_valid ? rd_data : '0;
   assign o_m_last    = o_m_valid && at_last;
   assign o_read_done = (state == BUF_DONE);
   assign o_count     = count;
   assign o_overflow  = overflow;
   assign o_state     = state;

endmodule

// File: tb/tb_npu_local_buffer.sv
// Bench for npu_local_buffer: queue-based reference model of the stored words,
// with a stream monitor comparing every presented beat against expectations.
module tb_npu_local_buffer;
   import npu_pkg::*;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = $clog2(DEPTH);

   logic              clk;
   logic              rst;
   logic [1:0]        sel;
   logic              en;
   logic              term;
   logic              pu_valid;
   logic [DATA_W-1:0] pu_data;
   logic              pool_valid;
   logic [DATA_W-1:0] pool_data;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic              m_ready;
   logic              read_done;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic [1:0]        dbg_state;

   logic [DATA_W:0]   exp_q[$];
   logic [DATA_W-1:0] model_mem[$];
   logic              model_ovf;
   int vectors;
   int miscompares;

   npu_local_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .i_clk              (clk),
      .i_reset            (rst),
      .i_sel_local_buffer (sel),
      .i_en_local_buffer  (en),
      .i_term             (term),
      .i_pu_valid         (pu_valid),
      .i_pu_data          (pu_data),
      .i_pool_valid       (pool_valid),
      .i_pool_data        (pool_data),
      .o_m_valid          (m_valid),
      .o_m_data           (m_data),
      .o_m_last           (m_last),
      .i_m_ready          (m_ready),
      .o_read_done        (read_done),
      .o_count            (count),
      .o_overflow         (overflow),
      .o_state            (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: every presented beat must match the head of the expected queue
   always @(negedge clk) begin
      if (!rst && m_valid) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat", m_data, m_last);
         end else begin
            if ({m_last, m_data} !== exp_q[0]) begin
               miscompares++;
               $display("FAIL stream_beat: got last %0b data 0x%0h, expected last %0b data 0x%0h",
                        m_last, m_data, exp_q[0][DATA_W], exp_q[0][DATA_W-1:0]);
            end
            if (m_ready) void'(exp_q.pop_front());
         end
      end
   end

   // driver tasks
   task automatic idle_inputs();
      sel = BUF_SEL_NONE; en = 1'b0; term = 1'b0;
      pu_valid = 1'b0; pool_valid = 1'b0; m_ready = 1'b0;
   endtask

   task automatic write_cycle(input logic [1:0] s, input logic pv, input logic [DATA_W-1:0] pd,
                              input logic qv, input logic [DATA_W-1:0] qd);
      sel = s; pu_valid = pv; pu_data = pd; pool_valid = qv; pool_data = qd;
      if ((s == BUF_SEL_PU && pv) || (s == BUF_SEL_POOL && qv)) begin
         if (model_mem.size() < DEPTH) model_mem.push_back((s == BUF_SEL_PU) ? pd : qd);
         else model_ovf = 1'b1;
      end
      step();
      pu_valid = 1'b0; pool_valid = 1'b0;
   endtask

   task automatic load_expected();
      for (int i = 0; i < model_mem.size(); i++)
         exp_q.push_back({(i == model_mem.size() - 1), model_mem[i]});
   endtask

   // ready_mode: 0 always ready, 1 random, 2 repeating 1,0,0,1
   task automatic drain(input int ready_mode);
      int cyc;
      int n;
      n = model_mem.size();
      load_expected();
      sel = BUF_SEL_CTRL; en = 1'b1; m_ready = 1'b1;
      step();
      if (n > 0) check("first_valid_latency", m_valid, 1'b1);
      else       check("empty_done_latency", read_done, 1'b1);
      cyc = 0;
      while (!read_done && cyc < 1000) begin
         case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         endcase
         step();
         cyc++;
      end
      if (!read_done) check("drain_timeout", 1'b0, 1'b1);
      check("drain_exp_left", exp_q.size(), 0);
      check("done_count_held", count, n);
      check("done_overflow", overflow, model_ovf);
      en = 1'b0; sel = BUF_SEL_NONE; m_ready = 1'b0;
      step();
      check("done_release", read_done, 1'b0);
      check("done_count_clear", count, 0);
      check("done_overflow_kept", overflow, model_ovf);
      model_mem.delete();
   endtask

   task automatic abort_mid_drain(input logic use_term);
      load_expected();
      sel = BUF_SEL_CTRL; en = 1'b1; m_ready = 1'b1;
      repeat (3) step();
      if (use_term) term = 1'b1; else rst = 1'b1;
      step();
      term = 1'b0; rst = 1'b0;
      exp_q.delete();
      model_mem.delete();
      model_ovf = 1'b0;
      check("abort_valid", m_valid, 1'b0);
      check("abort_data", m_data, 0);
      check("abort_last", m_last, 1'b0);
      check("abort_read_done", read_done, 1'b0);
      check("abort_count", count, 0);
      check("abort_overflow", overflow, 1'b0);
      check("abort_state", dbg_state, BUF_IDLE);
      idle_inputs();
      step();
   endtask

   initial begin
      vectors = 0; miscompares = 0; model_ovf = 1'b0;
      pu_data = '0; pool_data = '0;
      idle_inputs();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
      check("reset_valid", m_valid, 1'b0);
      check("reset_read_done", read_done, 1'b0);
      check("reset_count", count, 0);
      check("reset_overflow", overflow, 1'b0);
      check("reset_state", dbg_state, BUF_IDLE);

      // directed PU words then full-rate drain
      for (int i = 1; i <= 4; i++) write_cycle(BUF_SEL_PU, 1'b1, DATA_W'(i * 'h11), 1'b0, '0);
      check("pu_count", count, 4);
      drain(0);

      // pool select ignores PU valid; count advances one per cycle
      for (int i = 0; i < 6; i++) begin
         write_cycle(BUF_SEL_POOL, 1'b1, $urandom, 1'b1, $urandom);
         check("pool_count", count, model_mem.size());
      end
      drain(1);

      // random mixed sources including NONE
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 25; i++)
            write_cycle(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom,
                        1'($urandom_range(0, 1)), $urandom);
         check("mixed_count", count, model_mem.size());
         drain(1);
      end

      // overfill, then drain with a 1,0,0,1 ready pattern
      for (int i = 0; i < DEPTH + 1; i++) write_cycle(BUF_SEL_PU, 1'b1, $urandom, 1'b0, '0);
      check("full_count", count, DEPTH);
      check("full_overflow", overflow, 1'b1);
      drain(2);

      // empty drain goes straight to done
      drain(0);

      // reset mid-drain (overflow still set from the overfill)
      for (int i = 0; i < 6; i++) write_cycle(BUF_SEL_POOL, 1'b0, '0, 1'b1, $urandom);
      abort_mid_drain(1'b0);

      // flush mid-drain after a fresh overfill
      for (int i = 0; i < DEPTH + 1; i++) write_cycle(BUF_SEL_PU, 1'b1, $urandom, 1'b0, '0);
      abort_mid_drain(1'b1);

      // buffer usable again after flush
      for (int i = 0; i < 3; i++) write_cycle(BUF_SEL_PU, 1'b1, $urandom, 1'b0, '0);
      drain(1);

      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
